// File: rtl/mem_bus_pkg.sv
// Shared types for the native valid/ready memory bus initiator.
package mem_bus_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RSP  = 2'd2
  } initiator_state_t;

  localparam logic [3:0] WSTRB_READ = 4'b0000;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } mem_cmd_t;

endpackage

// File: rtl/mem_bus_initiator.sv
// Single-outstanding initiator for the native memory bus: accepts one command,
// drives the bus until mem_ready or timeout, then holds the response until consumed.
module mem_bus_initiator
  import mem_bus_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [31:0] cmd_addr,
  input  logic [31:0] cmd_wdata,
  input  logic [3:0]  cmd_wstrb,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err,
  output logic        busy,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic [31:0] mem_rdata,
  output logic [1:0]  dbg_state,
  output logic        dbg_misaligned
);

  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  // Handshakes: a transfer happens on any rising edge where valid && ready;
  // valid never depends on ready and payload is held stable while valid is high.
  initiator_state_t state_q, state_d;
  mem_cmd_t         cmd_q, cmd_d;
  logic             mem_valid_q, mem_valid_d;
  logic             rsp_valid_q, rsp_valid_d;
  logic [31:0]      rsp_rdata_q, rsp_rdata_d;
  logic             rsp_err_q, rsp_err_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             misaligned_q, misaligned_d;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      cmd_q        <= '0;
      mem_valid_q  <= 1'b0;
      rsp_valid_q  <= 1'b0;
      rsp_rdata_q  <= '0;
      rsp_err_q    <= 1'b0;
      cnt_q        <= '0;
      misaligned_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cmd_q        <= cmd_d;
      mem_valid_q  <= mem_valid_d;
      rsp_valid_q  <= rsp_valid_d;
      rsp_rdata_q  <= rsp_rdata_d;
      rsp_err_q    <= rsp_err_d;
      cnt_q        <= cnt_d;
      misaligned_q <= misaligned_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    cmd_d        = cmd_q;
    mem_valid_d  = mem_valid_q;
    rsp_valid_d  = rsp_valid_q;
    rsp_rdata_d  = rsp_rdata_q;
    rsp_err_d    = rsp_err_q;
    cnt_d        = cnt_q;
    misaligned_d = misaligned_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_valid) begin
          cmd_d.addr   = {cmd_addr[31:2], 2'b00};
          cmd_d.wdata  = cmd_wdata;
          cmd_d.wstrb  = cmd_wstrb;
          misaligned_d = |cmd_addr[1:0];
          mem_valid_d  = 1'b1;
          state_d      = REQ;
        end
      end
      REQ: begin
        cnt_d = cnt_q + 1'b1;
        // A completion in the timeout cycle still counts as success.
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          rsp_rdata_d = (cmd_q.wstrb == WSTRB_READ) ? mem_rdata : 32'h0;
          rsp_err_d   = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end else if (cnt_q == CNT_LAST) begin
          mem_valid_d = 1'b0;
          rsp_rdata_d = 32'h0;
          rsp_err_d   = 1'b1;
          rsp_valid_d = 1'b1;
          state_d     = RSP;
        end
      end
      RSP: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          cnt_d       = '0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    cmd_ready      = (state_q == IDLE);
    busy           = (state_q != IDLE);
    dbg_state      = state_q;
    dbg_misaligned = misaligned_q;
    mem_valid      = mem_valid_q;
    mem_addr       = cmd_q.addr;
    mem_wdata      = cmd_q.wdata;
    mem_wstrb      = cmd_q.wstrb;
    rsp_valid      = rsp_valid_q;
    rsp_rdata      = rsp_rdata_q;
    rsp_err        = rsp_err_q;
  end

endmodule

// File: tb/tb_mem_bus_initiator.sv
// Directed bench for mem_bus_initiator with a small BRAM responder and a response scoreboard.
module tb_mem_bus_initiator;
  import mem_bus_pkg::*;

  localparam int unsigned TO = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        cmd_valid, cmd_ready;
  logic [31:0] cmd_addr, cmd_wdata;
  logic [3:0]  cmd_wstrb;
  logic        rsp_valid, rsp_ready, rsp_err, busy;
  logic [31:0] rsp_rdata;
  logic        mem_valid, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_wstrb;
  logic [1:0]  dbg_state;
  logic        dbg_misaligned;

  mem_bus_initiator #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .reset(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_addr(cmd_addr),
    .cmd_wdata(cmd_wdata), .cmd_wstrb(cmd_wstrb),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .rsp_err(rsp_err), .busy(busy),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb), .mem_rdata(mem_rdata),
    .dbg_state(dbg_state), .dbg_misaligned(dbg_misaligned)
  );

  // Clock / reset
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_rsp  = 0;
  int vcnt   = 0;
  logic [32:0] exp_q[$];
  logic [67:0] exp_bus = '0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // BRAM responder: ready pulses three cycles after valid is seen
  logic [31:0] bram [16];
  logic        rdy_r;
  logic [31:0] rd_r;
  int          lat;
  logic        resp_en   = 1'b1;
  logic        force_rdy = 1'b0;

  assign mem_ready = rdy_r | force_rdy;
  assign mem_rdata = rd_r;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      rdy_r <= 1'b0;
      lat   <= 0;
      rd_r  <= '0;
      for (int i = 0; i < 16; i++) bram[i] <= '0;
      bram[0] <= 32'h5;
      bram[1] <= 32'hA;
    end else begin
      rdy_r <= 1'b0;
      if (mem_valid && !rdy_r && resp_en) begin
        if (lat == 2) begin
          rdy_r <= 1'b1;
          lat   <= 0;
          rd_r  <= bram[mem_addr[5:2]];
          for (int b = 0; b < 4; b++)
            if (mem_wstrb[b]) bram[mem_addr[5:2]][8*b +: 8] <= mem_wdata[8*b +: 8];
        end else begin
          lat <= lat + 1;
        end
      end else begin
        lat <= 0;
      end
    end
  end

  // Response monitor / scoreboard
  always @(negedge clk) begin
    if (!rst && rsp_valid && rsp_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_fail++;
        $display("FAIL unexpected_rsp: got 0x%0h expected no response", {rsp_err, rsp_rdata});
      end else begin
        check("rsp", {63'b0, rsp_err, rsp_rdata}, {63'b0, exp_q.pop_front()});
      end
      n_rsp++;
    end
  end

  // Bus monitor: payload stability and valid dropping on the ready edge
  logic prev_done = 1'b0;
  always @(posedge clk) prev_done <= mem_valid && mem_ready;

  always @(negedge clk) begin
    if (!rst) begin
      if (prev_done) check("valid_after_ready", {95'b0, mem_valid}, 96'd0);
      if (mem_valid) begin
        vcnt++;
        check("bus_payload", {28'b0, mem_addr, mem_wdata, mem_wstrb}, {28'b0, exp_bus});
      end
    end
  end

  // Driver tasks (called in the posedge+1 phase)
  task automatic send_cmd(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          input logic want_rsp, input logic [32:0] e);
    int k = 0;
    while (!cmd_ready && k < 100) begin
      @(posedge clk); #1;
      k++;
    end
    check("cmd_ready_wait", {95'b0, cmd_ready}, 96'd1);
    if (!cmd_ready) return;
    exp_bus = {a[31:2], 2'b00, wd, ws};
    if (want_rsp) exp_q.push_back(e);
    cmd_valid = 1'b1;
    cmd_addr  = a;
    cmd_wdata = wd;
    cmd_wstrb = ws;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(input int target);
    int k = 0;
    while (n_rsp < target && k < 200) begin
      @(posedge clk); #1;
      k++;
    end
    check("rsp_wait", {95'b0, n_rsp >= target}, 96'd1);
  endtask

  task automatic wait_rsp_valid();
    int k = 0;
    while (!rsp_valid && k < 50) begin
      @(posedge clk); #1;
      k++;
    end
    check("rsp_valid_wait", {95'b0, rsp_valid}, 96'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish before 100000");
    $fatal(1, "watchdog expired");
  end

  int v0;
  initial begin
    rst = 1'b1;
    cmd_valid = 1'b0; cmd_addr = '0; cmd_wdata = '0; cmd_wstrb = '0;
    rsp_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("reset_bus", {27'b0, mem_valid, mem_addr, mem_wdata, mem_wstrb}, 96'd0);
    check("reset_rsp", {63'b0, rsp_valid, rsp_err, rsp_rdata}, 96'd0);
    check("reset_ctrl", {94'b0, cmd_ready, busy}, 96'd2);
    @(posedge clk); #1 rst = 1'b0;
    @(posedge clk); #1;

    // Read word 1, consumer always ready
    send_cmd(32'h4, 32'h0, 4'h0, 1'b1, {1'b0, 32'hA});
    check("aligned_flag", {95'b0, dbg_misaligned}, 96'd0);
    wait_rsp(1);

    // Read word 0 with response backpressure
    rsp_ready = 1'b0;
    send_cmd(32'h0, 32'h0, 4'h0, 1'b1, {1'b0, 32'h5});
    wait_rsp_valid();
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp_hold", {61'b0, rsp_valid, cmd_ready, rsp_err, rsp_rdata}, {61'b0, 3'b100, 32'h5});
    end
    @(posedge clk); #1 rsp_ready = 1'b1;
    @(negedge clk);
    check("bp_state_rsp", {94'b0, dbg_state}, {94'b0, RSP});
    @(negedge clk);
    check("bp_state_idle", {94'b0, dbg_state}, {94'b0, IDLE});
    @(posedge clk); #1;
    wait_rsp(2);

    // Write then read back
    send_cmd(32'h8, 32'hDEADBEEF, 4'hF, 1'b1, {1'b0, 32'h0});
    send_cmd(32'h8, 32'h0, 4'h0, 1'b1, {1'b0, 32'hDEADBEEF});
    wait_rsp(4);

    // Responder silent: timeout after exactly TO cycles of valid
    resp_en = 1'b0;
    v0 = vcnt;
    send_cmd(32'h0, 32'h0, 4'h0, 1'b1, {1'b1, 32'h0});
    wait_rsp(5);
    check("timeout_valid_cycles", vcnt - v0, TO);
    resp_en = 1'b1;
    send_cmd(32'h4, 32'h0, 4'h0, 1'b1, {1'b0, 32'hA});
    wait_rsp(6);

    // Asynchronous reset mid-request: no response may follow
    send_cmd(32'h0, 32'h0, 4'h0, 1'b0, 33'h0);
    check("pre_reset_valid", {95'b0, mem_valid}, 96'd1);
    @(posedge clk); #3 rst = 1'b1;
    #1;
    check("async_reset_drop", {93'b0, mem_valid, rsp_valid, busy}, 96'd0);
    @(posedge clk); #3 rst = 1'b0;
    repeat (8) begin
      @(posedge clk); #1;
    end
    check("post_reset_ctrl", {94'b0, cmd_ready, rsp_valid}, 96'd2);

    // mem_ready in IDLE is ignored; misaligned address is word-aligned on the bus
    force_rdy = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("idle_ready_ignored", {94'b0, busy, rsp_valid}, 96'd0);
    end
    @(posedge clk); #1 force_rdy = 1'b0;
    send_cmd(32'h7, 32'h0, 4'h0, 1'b1, {1'b0, 32'hA});
    @(negedge clk);
    check("misaligned_addr", {64'b0, mem_addr}, 96'h4);
    check("misaligned_flag", {95'b0, dbg_misaligned}, 96'd1);
    @(posedge clk); #1;
    wait_rsp(7);

    repeat (4) @(posedge clk);
    check("queue_empty", exp_q.size(), 96'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
